stream_gen_mc: RTL and testbench

Parametrised multi-channel AXI4-Stream test-pattern generator, the next generation of the single-channel stream_gen that feeds the DMA S2MM stream input in the PL.
- Produces framed packets of configurable length and selectable pattern.
- Channels are served round-robin and tagged on tdest.
- An idle gap of configurable length separates packets.
- Reports per-packet completion for interrupt and IRQ-vector use.

---
 rtl/stream_gen_pkg.sv | 28 ++
 rtl/stream_gen_mc_rr_sel.sv | 32 +++
 rtl/stream_gen_mc.sv | 164 ++++++++++++++++
 tb/tb_stream_gen_mc.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_gen_pkg.sv
// Shared types and LFSR helper for the multi-channel stream generator.
// Pattern modes, FSM states and the Galois LFSR step live here.
package stream_gen_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_INDEX = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Right-shift Galois step; the +1 term is the bit shifted out and
  // re-entering at the top, so only the remaining taps are XORed in.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] t;
    t = {1'b0, s[31:1]};
    if (s[0]) t = t ^ {LFSR_POLY[31:1], 1'b0};
    return t;
  endfunction

endpackage

// File: rtl/stream_gen_mc_rr_sel.sv
// Round-robin finder: first set mask bit strictly after the pointer,
// wrapping around; o_valid low when the mask is empty.
module stream_rr_sel
  import stream_gen_pkg::*;
#(
  parameter int NCHAN = 4,
  parameter int CW    = 2
) (
  input  logic [NCHAN-1:0] i_mask,
  input  logic [CW-1:0]    i_ptr,
  output logic [CW-1:0]    o_idx,
  output logic             o_valid
);

  logic [CW:0] w_c;

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    w_c     = '0;
    for (int k = NCHAN; k >= 1; k--) begin
      w_c = {1'b0, i_ptr} + (CW+1)'(k);
      if (w_c >= (CW+1)'(NCHAN)) w_c = w_c - (CW+1)'(NCHAN);
      if (i_mask[w_c[CW-1:0]]) begin
        o_idx   = w_c[CW-1:0];
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_gen_mc.sv
// Multi-channel AXI4-Stream pattern generator: round-robin channels
// on tdest, framed packets, idle gaps, per-packet completion pulse.
module stream_gen_mc
  import stream_gen_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NCHAN  = 4,
  parameter int LEN_W  = 16,
  parameter int GAP_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [LEN_W-1:0]     pkt_len,
  input  logic [GAP_W-1:0]     gap,
  input  logic [NCHAN-1:0]     chan_en,
  output logic [DATA_W-1:0]    tdata,
  output logic [DATA_W/8-1:0]  tkeep,
  output logic                 tlast,
  output logic                 tvalid,
  input  logic                 tready,
  output logic [((NCHAN > 1) ? $clog2(NCHAN) : 1)-1:0] tdest,
  output logic                 pkt_done,
  output logic [31:0]          pkt_count
);

  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int NW = DATA_W / 32;

  state_t            r_state;
  mode_t             r_mode;
  logic              r_valid;
  logic              r_done;
  logic [CW-1:0]     r_chan;
  logic [CW-1:0]     r_ptr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_beat;
  logic [GAP_W-1:0]  r_gap;
  logic [31:0]       r_pcnt;
  logic [31:0]       r_cnt  [NCHAN];
  logic [31:0]       r_lfsr [NCHAN];

  logic [CW-1:0]     w_sel;
  logic              w_sel_v;
  logic              w_go;
  logic              w_acc;
  logic              w_last;
  logic              w_start;
  logic [31:0]       w_word;
  logic [DATA_W-1:0] w_data;

  stream_rr_sel #(
    .NCHAN (NCHAN),
    .CW    (CW)
  ) u_sel (
    .i_mask  (chan_en),
    .i_ptr   (r_ptr),
    .o_idx   (w_sel),
    .o_valid (w_sel_v)
  );

  assign w_go   = enable && w_sel_v;
  assign w_acc  = r_valid && tready;
  assign w_last = (r_beat == r_len - LEN_W'(1));

  // Launch a packet from idle, at the end of a gap, or back-to-back.
  always_comb begin
    w_start = 1'b0;
    unique case (r_state)
      ST_IDLE: w_start = w_go;
      ST_GAP:  w_start = w_go && (r_gap <= GAP_W'(1));
      ST_SEND: w_start = w_go && w_acc && w_last && (gap == '0);
      default: w_start = 1'b0;
    endcase
  end

  // Pattern word for the current channel and beat.
  always_comb begin
    w_word = r_cnt[r_chan];
    if (r_mode == MODE_LFSR) w_word = r_lfsr[r_chan];
    w_data = {NW{w_word}};
    if (r_mode == MODE_INDEX) begin
      w_data       = '0;
      w_data[31:0] = {8'(r_chan), 24'(r_beat)};
    end
  end

  // Packet framing FSM; launch fields are latched last so they win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_COUNT;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_chan  <= '0;
      r_ptr   <= CW'(NCHAN - 1);
      r_len   <= LEN_W'(1);
      r_beat  <= '0;
      r_gap   <= '0;
      r_pcnt  <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: ;
        ST_GAP: begin
          if (r_gap > GAP_W'(1)) r_gap <= r_gap - GAP_W'(1);
          else if (!w_go) r_state <= ST_IDLE;
        end
        ST_SEND: begin
          if (w_acc) begin
            if (!w_last) begin
              r_beat <= r_beat + LEN_W'(1);
            end else begin
              r_done <= 1'b1;
              r_pcnt <= r_pcnt + 32'd1;
              if (!w_go) begin
                r_valid <= 1'b0;
                r_state <= ST_IDLE;
              end else if (gap != '0) begin
                r_valid <= 1'b0;
                r_gap   <= gap;
                r_state <= ST_GAP;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_start) begin
        r_state <= ST_SEND;
        r_valid <= 1'b1;
        r_chan  <= w_sel;
        r_ptr   <= w_sel;
        r_beat  <= '0;
        r_len   <= (pkt_len == '0) ? LEN_W'(1) : pkt_len;
        r_mode  <= (mode == 2'd1) ? MODE_LFSR :
                   (mode == 2'd2) ? MODE_INDEX : MODE_COUNT;
      end
    end
  end

  // Per-channel pattern state advances only on accepted beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCHAN; k++) begin
        r_cnt[k]  <= '0;
        r_lfsr[k] <= 32'(k + 1);
      end
    end else if (w_acc) begin
      if (r_mode == MODE_COUNT) r_cnt[r_chan] <= r_cnt[r_chan] + 32'd1;
      if (r_mode == MODE_LFSR) r_lfsr[r_chan] <= lfsr_next(r_lfsr[r_chan]);
    end
  end

  assign tdata     = w_data;
  assign tkeep     = '1;
  assign tlast     = r_valid && w_last;
  assign tvalid    = r_valid;
  assign tdest     = r_chan;
  assign pkt_done  = r_done;
  assign pkt_count = r_pcnt;

endmodule

// File: tb/tb_stream_gen_mc.sv
// Self-checking bench for stream_gen_mc: table-driven packet runs
// against a beat scoreboard, plus hand-written corner sequences.
module tb_stream_gen_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  mode;
  logic [15:0] pkt_len;
  logic [7:0]  gap;
  logic [3:0]  chan_en;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready;
  logic [1:0]  tdest;
  logic        pkt_done;
  logic [31:0] pkt_count;

  stream_gen_mc #(
    .DATA_W (32),
    .NCHAN  (4),
    .LEN_W  (16),
    .GAP_W  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .mode      (mode),
    .pkt_len   (pkt_len),
    .gap       (gap),
    .chan_en   (chan_en),
    .tdata     (tdata),
    .tkeep     (tkeep),
    .tlast     (tlast),
    .tvalid    (tvalid),
    .tready    (tready),
    .tdest     (tdest),
    .pkt_done  (pkt_done),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [3:0] en;
    int         len;
    int         gap;
    int         npkt;
    int         rdy;
    int         drop;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [1:0]  dest;
  } exp_t;

  exp_t        q[$];
  vec_t        tbl[6];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_cnt[4];
  logic [31:0] m_lfsr[4];
  int          m_ptr;

  function automatic logic [31:0] m_step(input logic [31:0] s);
    if (s[0]) return (s >> 1) ^ 32'h8020_0002;
    return s >> 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_cnt[k]  = 32'd0;
      m_lfsr[k] = 32'(k + 1);
    end
    m_ptr = 3;
    q.delete();
  endtask

  task automatic push_pkts(input vec_t v);
    int   c;
    int   l;
    exp_t e;
    l = (v.len == 0) ? 1 : v.len;
    for (int p = 0; p < v.npkt; p++) begin
      c = -1;
      for (int k = 1; k <= 4; k++) begin
        if (c < 0 && v.en[(m_ptr + k) % 4]) c = (m_ptr + k) % 4;
      end
      m_ptr = c;
      for (int b = 0; b < l; b++) begin
        e.last = (b == l - 1);
        e.dest = 2'(c);
        if (v.mode == 2'd1) begin
          e.data    = m_lfsr[c];
          m_lfsr[c] = m_step(m_lfsr[c]);
        end else if (v.mode == 2'd2) begin
          e.data = {8'(c), 24'(b)};
        end else begin
          e.data   = m_cnt[c];
          m_cnt[c] = m_cnt[c] + 32'd1;
        end
        q.push_back(e);
      end
    end
  endtask

  task automatic push_const(input logic [31:0] d, input logic l,
                            input logic [1:0] dst);
    exp_t e;
    e.data = d;
    e.last = l;
    e.dest = dst;
    q.push_back(e);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    enable  = 1'b0;
    tready  = 1'b0;
    mode    = 2'd0;
    pkt_len = 16'd0;
    gap     = 8'd0;
    chan_en = 4'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || pkt_done !== 1'b0 ||
        tdata !== 32'd0 || tdest !== 2'd0 || pkt_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_state v=%b l=%b d=%b data=%h dest=%0d cnt=%0d want all zero",
               tvalid, tlast, pkt_done, tdata, tdest, pkt_count);
    end
    checks++;
    if (tkeep !== 4'hF) begin
      failures++;
      $display("FAIL reset_tkeep got=%h want=f", tkeep);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_vec(input vec_t v, input bit use_model);
    int          cyc;
    int          acc;
    int          beat;
    int          gcnt;
    int          pulses;
    int          extra;
    bit          gap_pend;
    bit          stall;
    logic [31:0] pd;
    logic        pl;
    logic [1:0]  pdst;
    exp_t        e;
    if (use_model) push_pkts(v);
    mode     = v.mode;
    chan_en  = v.en;
    pkt_len  = 16'(v.len);
    gap      = 8'(v.gap);
    enable   = 1'b1;
    cyc      = 0;
    acc      = 0;
    beat     = 0;
    gcnt     = 0;
    pulses   = 0;
    gap_pend = 1'b0;
    stall    = 1'b0;
    pd       = '0;
    pl       = 1'b0;
    pdst     = '0;
    while (acc < v.npkt && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      tready = ($urandom_range(99) < v.rdy);
      pulses += int'(pkt_done);
      if (stall) begin
        checks++;
        if (!(tvalid && tdata == pd && tlast == pl && tdest == pdst)) begin
          failures++;
          $display("FAIL stall_hold v=%b data=%h last=%b dest=%0d want 1 %h %b %0d",
                   tvalid, tdata, tlast, tdest, pd, pl, pdst);
        end
      end
      if (gap_pend) begin
        if (tvalid) begin
          checks++;
          if (gcnt != v.gap) begin
            failures++;
            $display("FAIL gap_len got=%0d want=%0d", gcnt, v.gap);
          end
          gap_pend = 1'b0;
        end else begin
          gcnt++;
        end
      end
      stall = tvalid && !tready;
      pd    = tdata;
      pl    = tlast;
      pdst  = tdest;
      if (tvalid && tready) begin
        if (acc == v.npkt - 1 && beat == v.drop) enable = 1'b0;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL beat_extra data=%h last=%b dest=%0d want none",
                   tdata, tlast, tdest);
        end else begin
          e = q.pop_front();
          if (tdata !== e.data || tlast !== e.last || tdest !== e.dest) begin
            failures++;
            $display("FAIL beat data=%h last=%b dest=%0d want %h %b %0d",
                     tdata, tlast, tdest, e.data, e.last, e.dest);
          end
        end
        beat++;
        if (tlast) begin
          acc++;
          beat = 0;
          if (acc < v.npkt) begin
            gap_pend = 1'b1;
            gcnt     = 0;
          end
        end
      end
    end
    enable = 1'b0;
    checks++;
    if (cyc >= 4000) begin
      failures++;
      $display("FAIL timeout packets=%0d want %0d", acc, v.npkt);
    end
    tready = 1'b1;
    extra  = 0;
    repeat (10) begin
      @(negedge clk);
      pulses += int'(pkt_done);
      extra  += int'(tvalid);
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL idle_after valid_cycles=%0d want 0", extra);
    end
    checks++;
    if (pkt_count !== 32'(v.npkt)) begin
      failures++;
      $display("FAIL pkt_count got=%0d want=%0d", pkt_count, v.npkt);
    end
    checks++;
    if (pulses != v.npkt) begin
      failures++;
      $display("FAIL pkt_done pulses=%0d want=%0d", pulses, v.npkt);
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL beats_missing left=%0d want 0", q.size());
    end
  endtask

  initial begin
    vec_t v;
    int   nv;
    tbl[0] = '{2'd0, 4'b1111, 4, 0, 5, 100, 0};
    tbl[1] = '{2'd2, 4'b1111, 5, 3, 6, 50, 0};
    tbl[2] = '{2'd0, 4'b0001, 8, 0, 1, 100, 2};
    tbl[3] = '{2'd1, 4'b1010, 2, 1, 4, 50, 1};
    tbl[4] = '{2'd3, 4'b0110, 0, 2, 5, 70, 0};
    tbl[5] = '{2'd1, 4'b1111, 3, 0, 3, 60, 2};

    for (int i = 0; i < 6; i++) begin
      do_reset();
      run_vec(tbl[i], 1'b1);
    end

    do_reset();
    push_const(32'h0000_0001, 1'b0, 2'd0);
    push_const(32'h8020_0002, 1'b0, 2'd0);
    push_const(32'h4010_0001, 1'b1, 2'd0);
    v = '{2'd1, 4'b0001, 3, 0, 1, 100, 0};
    run_vec(v, 1'b0);

    do_reset();
    enable  = 1'b1;
    chan_en = 4'b0000;
    tready  = 1'b1;
    nv      = 0;
    repeat (20) begin
      @(negedge clk);
      nv += int'(tvalid);
    end
    enable = 1'b0;
    checks++;
    if (nv != 0 || pkt_count !== 32'd0) begin
      failures++;
      $display("FAIL no_chan valid_cycles=%0d cnt=%0d want 0 0", nv, pkt_count);
    end

    do_reset();
    enable  = 1'b1;
    chan_en = 4'b0001;
    pkt_len = 16'd8;
    tready  = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (tvalid !== 1'b1) begin
      failures++;
      $display("FAIL mid_pkt_valid got=%b want=1", tvalid);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (tvalid !== 1'b0 || tlast !== 1'b0) begin
      failures++;
      $display("FAIL async_reset v=%b l=%b want 0 0", tvalid, tlast);
    end
    do_reset();
    push_const(32'd0, 1'b0, 2'd0);
    push_const(32'd1, 1'b0, 2'd0);
    push_const(32'd2, 1'b0, 2'd0);
    push_const(32'd3, 1'b1, 2'd0);
    v = '{2'd0, 4'b0001, 4, 0, 1, 100, 0};
    run_vec(v, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
